avalon_mm_master: RTL

AVALON_MM_MASTER -- requirements
Module: avalon_mm_master

---
 rtl/avalon_mm_master.sv | 138 +++++++++++++
 1 files changed

// File: rtl/avalon_mm_master.sv
// Single-outstanding Avalon-MM master: accepts one command, runs it on m0_*, returns one response.
// Optional per-transaction watchdog enabled by defining AVM_MASTER_TIMEOUT_EN.
module avalon_mm_master #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [23:0] m0_address,
  output logic        m0_read,
  output logic        m0_write,
  output logic [31:0] m0_writedata,
  output logic [3:0]  m0_byteenable,
  output logic        m0_burstcount,
  output logic        m0_debugaccess,
  input  logic        m0_waitrequest,
  input  logic [31:0] m0_readdata,
  input  logic        m0_readdatavalid
);

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, RSP} state_t;
  state_t state;

  // Gated by reset so cmd_ready is low while held in reset and high on the first cycle after release.
  assign cmd_ready      = (state == IDLE) && reset_reset_n;
  assign m0_burstcount  = 1'b1;
  assign m0_debugaccess = 1'b0;

`ifdef AVM_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  logic        rsp_error_q;
  assign rsp_error = rsp_error_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, 16'(TIMEOUT_CYCLES)};
  assign rsp_error  = 1'b0;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state         <= IDLE;
      rsp_valid     <= 1'b0;
      rsp_data      <= 32'h0;
      m0_read       <= 1'b0;
      m0_write      <= 1'b0;
      m0_address    <= 24'h0;
      m0_writedata  <= 32'h0;
      m0_byteenable <= 4'h0;
`ifdef AVM_MASTER_TIMEOUT_EN
      tmo_cnt       <= 16'h0;
      rsp_error_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state         <= REQ;
            m0_address    <= cmd_addr;
            m0_writedata  <= cmd_wdata;
            m0_byteenable <= cmd_be;
            m0_read       <= ~cmd_write;
            m0_write      <= cmd_write;
`ifdef AVM_MASTER_TIMEOUT_EN
            tmo_cnt       <= 16'h0;
            rsp_error_q   <= 1'b0;
`endif
          end
        end
        REQ: begin
          // Completion is tested before the watchdog so it wins a same-cycle tie.
          if (!m0_waitrequest) begin
            m0_read  <= 1'b0;
            m0_write <= 1'b0;
            if (m0_write) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_data  <= 32'h0;
            end else if (m0_readdatavalid) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_data  <= m0_readdata;
            end else begin
              state <= RDWAIT;
            end
          end
`ifdef AVM_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            m0_read     <= 1'b0;
            m0_write    <= 1'b0;
            state       <= RSP;
            rsp_valid   <= 1'b1;
            rsp_data    <= ERR_DATA;
            rsp_error_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'h1;
          end
`endif
        end
        RDWAIT: begin
          if (m0_readdatavalid) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_data  <= m0_readdata;
          end
`ifdef AVM_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state       <= RSP;
            rsp_valid   <= 1'b1;
            rsp_data    <= ERR_DATA;
            rsp_error_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'h1;
          end
`endif
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
